// File: rtl/lzd_pkg.sv
// Shared definitions for the pipelined leading-zero detector.
// Holds the sizing helpers that derive tree geometry from the operand width and
// the encoding constants used by the merge nodes.
package lzd_pkg;

    // Ceiling log2 for n >= 1; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Tree depth: operand padded to the next power of two, at least one level.
    function automatic int unsigned lzd_levels(input int unsigned width);
        return (width < 2) ? 1 : clog2(width);
    endfunction

    // Padded operand width P.
    function automatic int unsigned lzd_pad_w(input int unsigned width);
        return 1 << lzd_levels(width);
    endfunction

    // Number of registered tree stages.
    function automatic int unsigned lzd_tree_stg(input int unsigned width,
                                                 input int unsigned lvl_per_stg);
        return (lzd_levels(width) + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

    // Width of the count output, wide enough to hold WIDTH itself.
    function automatic int unsigned lzd_cnt_w(input int unsigned width);
        return clog2(width + 1);
    endfunction

    // Position MSB prepended by a merge node: 0 when the first one sits in the
    // left (more significant) child, 1 when it sits in the right child.
    localparam logic PosLeft  = 1'b0;
    localparam logic PosRight = 1'b1;

endpackage

// File: rtl/lzd_merge.sv
// Combinational node of the leading-zero tree.
// PW = 0 builds a leaf over a bit pair (vl = left bit, vr = right bit).
// PW > 0 merges two children, each carrying a valid flag and a PW-bit position.
// Ports:
//   vl, pl : left (more significant) child valid / position
//   vr, pr : right child valid / position
//   v, p   : merged valid / (PW+1)-bit position of the first one
module lzd_merge
    import lzd_pkg::*;
#(
    parameter int unsigned PW = 0
) (
    input  logic                         vl,
    input  logic [(PW > 0 ? PW : 1)-1:0] pl,
    input  logic                         vr,
    input  logic [(PW > 0 ? PW : 1)-1:0] pr,
    output logic                         v,
    output logic [PW:0]                  p
);

    assign v = vl | vr;

    if (PW == 0) begin : g_leaf
        // Leaf positions are meaningless; keep the ports uniform and sink them.
        logic unused_pos;
        assign unused_pos = ^{pl, pr};
        assign p = (~vl & vr) ? PosRight : PosLeft;
    end else begin : g_node
        assign p = vl ? {PosLeft, pl} : {PosRight, pr};
    end

endmodule

// File: rtl/lzd_pipe.sv
// Pipelined, parametrised leading-zero detector with valid/ready flow control.
// The operand is zero-padded on the LSB side to a power of two, reduced by a
// binary tree of lzd_merge nodes with a register after every LVL_PER_STG levels
// (the last level always registered), then normalised in one final stage.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_ready = out_ready | ~out_valid)
//   in_data, in_tag      : operand and sideband tag
//   out_valid/out_ready  : result handshake
//   out_cnt              : leading-zero count (WIDTH when operand is zero)
//   out_zero             : operand was all zeros
//   out_norm             : operand shifted left by out_cnt
//   out_tag              : tag travelling with the operand
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int unsigned WIDTH       = 48,
    parameter int unsigned LVL_PER_STG = 2,
    parameter int unsigned TAG_W       = 4,
    localparam int unsigned CNT_W      = lzd_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LEVELS   = lzd_levels(WIDTH);
    localparam int unsigned P        = lzd_pad_w(WIDTH);
    localparam int unsigned TREE_STG = lzd_tree_stg(WIDTH, LVL_PER_STG);

    // Whole pipeline moves together; it only holds when the output is stuck.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [P-1:0] pad;
    if (P > WIDTH) begin : g_pad
        assign pad = {in_data, {(P - WIDTH){1'b0}}};
    end else begin : g_nopad
        assign pad = in_data;
    end

    // Level 0 is the padded operand; level l holds P>>l nodes of l-bit positions.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N   = P >> l;
        localparam int unsigned PWL = (l == 0) ? 1 : l;
        localparam int unsigned PWP = (l <= 1) ? 1 : l - 1;

        logic [N-1:0]     v;
        logic [N*PWL-1:0] p;

        if (l == 0) begin : g_src
            assign v = pad;
            assign p = '0;
        end else begin : g_tree
            logic [N-1:0]   vc;
            logic [N*l-1:0] pc;

            for (genvar n = 0; n < N; n++) begin : g_node
                lzd_merge #(
                    .PW(l - 1)
                ) u_merge (
                    .vl(g_lvl[l-1].v[2*n+1]),
                    .pl(g_lvl[l-1].p[(2*n+1)*PWP +: PWP]),
                    .vr(g_lvl[l-1].v[2*n]),
                    .pr(g_lvl[l-1].p[(2*n)*PWP +: PWP]),
                    .v (vc[n]),
                    .p (pc[n*l +: l])
                );
            end

            if ((l % LVL_PER_STG) == 0 || l == LEVELS) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v <= '0;
                        p <= '0;
                    end else if (adv) begin
                        v <= vc;
                        p <= pc;
                    end
                end
            end else begin : g_comb
                assign v = vc;
                assign p = pc;
            end
        end
    end

    logic              tree_v;
    logic [LEVELS-1:0] tree_p;
    assign tree_v = g_lvl[LEVELS].v[0];
    assign tree_p = g_lvl[LEVELS].p;

    // Valid, data and tag shadow the registered tree levels.
    logic             stg_valid [TREE_STG];
    logic [WIDTH-1:0] stg_data  [TREE_STG];
    logic [TAG_W-1:0] stg_tag   [TREE_STG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < TREE_STG; s++) begin
                stg_valid[s] <= 1'b0;
                stg_data[s]  <= '0;
                stg_tag[s]   <= '0;
            end
        end else if (adv) begin
            stg_valid[0] <= in_valid;
            stg_data[0]  <= in_data;
            stg_tag[0]   <= in_tag;
            for (int s = 1; s < TREE_STG; s++) begin
                stg_valid[s] <= stg_valid[s-1];
                stg_data[s]  <= stg_data[s-1];
                stg_tag[s]   <= stg_tag[s-1];
            end
        end
    end

    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] norm_d;

    always_comb begin
        cnt_d  = tree_v ? CNT_W'(tree_p) : CNT_W'(WIDTH);
        // A zero operand shifts to zero regardless of the count.
        norm_d = stg_data[TREE_STG-1] << cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= stg_valid[TREE_STG-1];
            out_cnt   <= cnt_d;
            out_zero  <= ~tree_v;
            out_norm  <= norm_d;
            out_tag   <= stg_tag[TREE_STG-1];
        end
    end

endmodule

// File: tb/tb_lzd_pipe.sv
// Self-checking bench for lzd_pipe (WIDTH=48, LVL_PER_STG=2, TAG_W=4).
module tb_lzd_pipe;

    localparam int unsigned WIDTH = 48;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 6;
    localparam int          LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic             out_zero;
    logic [WIDTH-1:0] out_norm;
    logic [TAG_W-1:0] out_tag;

    lzd_pipe #(
        .WIDTH      (WIDTH),
        .LVL_PER_STG(2),
        .TAG_W      (TAG_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cnt  (out_cnt),
        .out_zero (out_zero),
        .out_norm (out_norm),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan for the highest set bit, shift it to the top.
    function automatic logic [63:0] model(input logic [47:0] d, input logic [3:0] t);
        int          c;
        logic [47:0] n;
        c = 48;
        for (int i = 0; i < 48; i++) if (d[i]) c = 47 - i;
        n = d << c;
        return {5'b0, 6'(c), (d == 48'h0), n, t};
    endfunction

    function automatic logic [63:0] pack_out();
        return {5'b0, out_cnt, out_zero, out_norm, out_tag};
    endfunction

    // Scoreboard: expected results in acceptance order.
    logic [63:0] exp_q[$];

    always @(negedge rst_n) exp_q.delete();

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_tag));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious: got %0h want none", pack_out());
                end else begin
                    check("scoreboard", pack_out(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // One operand into an idle pipeline; lat = cycles from acceptance to out_valid.
    task automatic send_one(input logic [47:0] d, input logic [3:0] t, output int lat);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    typedef struct {
        logic [47:0] data;
        logic [3:0]  tag;
        logic [5:0]  cnt;
        logic        zero;
        logic [47:0] norm;
    } vec_t;

    vec_t        vt [8];
    int          lat;
    int          k;
    int          rcv;
    int          sent;
    int          wait_c;
    bit          got;
    bit          accepted;
    logic [63:0] held;

    initial begin
        vt[0] = '{48'h8000_0000_0000, 4'h3, 6'd0,  1'b0, 48'h8000_0000_0000};
        vt[1] = '{48'h0000_0000_0001, 4'h1, 6'd47, 1'b0, 48'h8000_0000_0000};
        vt[2] = '{48'h0000_0F00_0000, 4'h2, 6'd20, 1'b0, 48'hF000_0000_0000};
        vt[3] = '{48'h0000_0000_0000, 4'h9, 6'd48, 1'b1, 48'h0000_0000_0000};
        vt[4] = '{48'hFFFF_FFFF_FFFF, 4'hF, 6'd0,  1'b0, 48'hFFFF_FFFF_FFFF};
        vt[5] = '{48'h0001_2345_6789, 4'h6, 6'd15, 1'b0, 48'h91A2_B3C4_8000};
        vt[6] = '{48'h0000_0000_8000, 4'h7, 6'd32, 1'b0, 48'h8000_0000_0000};
        vt[7] = '{48'h0000_8000_0001, 4'hC, 6'd16, 1'b0, 48'h8000_0001_0000};

        // Reset held with an operand offered.
        in_valid  = 1'b1;
        in_data   = 48'h0000_1234_5678;
        in_tag    = 4'h5;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_valid", out_valid, 0);
            check("reset_outputs", pack_out(), 0);
            check("reset_in_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            send_one(vt[i].data, vt[i].tag, lat);
            check("vec_latency", lat, LAT);
            check("vec_cnt", out_cnt, vt[i].cnt);
            check("vec_zero", out_zero, vt[i].zero);
            check("vec_norm", out_norm, vt[i].norm);
            check("vec_tag", out_tag, vt[i].tag);
        end
        repeat (2) @(posedge clk);

        // 48 back-to-back operands with a 3-cycle output stall.
        k    = 0;
        rcv  = 0;
        got  = 0;
        held = '0;
        for (int c = 0; c < 300 && rcv < 48; c++) begin
            @(posedge clk);
            #1;
            in_valid  = (k < 48);
            in_data   = 48'h8000_0000_0000 >> k;
            in_tag    = 4'(k);
            out_ready = !(c >= 6 && c <= 8);
            @(negedge clk);
            check("stream_in_ready", in_ready, (c >= 6 && c <= 8) ? 0 : 1);
            if (c == 6) begin
                held = pack_out();
                check("stall_valid", out_valid, 1);
            end
            if (c >= 7 && c <= 9) check("stall_hold", pack_out(), held);
            if (got && rcv < 48) check("stream_gap", out_valid, 1);
            if (out_valid && out_ready) begin
                check("stream_order", {out_cnt, out_tag}, {6'(rcv), 4'(rcv)});
                rcv++;
                got = 1;
            end
            if (in_valid && in_ready) k++;
        end
        check("stream_count", rcv, 48);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Randomised traffic with random backpressure; source holds until taken.
        sent     = 0;
        accepted = 1;
        for (int c = 0; c < 3000 && sent < 200; c++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 48'({$urandom, $urandom}) >> $urandom_range(0, 48);
                in_tag   = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("ready_rule", in_ready, out_ready || !out_valid);
            accepted = in_valid && in_ready;
            if (accepted) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_c    = 0;
        while (exp_q.size() != 0 && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        check("drain_empty", exp_q.size(), 0);

        // Reset mid-stream with three operands in flight, output stalled.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 48'h0000_00FF_0000 >> i;
            in_tag   = 4'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_c   = 0;
        while (!out_valid && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        check("midrst_filled", out_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_async_valid", out_valid, 0);
        check("midrst_async_out", pack_out(), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        send_one(48'h0000_0000_0001, 4'hA, lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_cnt", out_cnt, 47);
        check("post_rst_norm", out_norm, 48'h8000_0000_0000);
        check("post_rst_tag", out_tag, 4'hA);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzd_pipe.md
Name: lzd_pipe

Overview:
- Parametrised, pipelined leading-zero detector for the noise-generator datapath.
- Takes a WIDTH-bit operand and returns:
  - the leading-zero count,
  - an all-zero flag,
  - the operand left-normalised so its MSB is set.
- Used ahead of log/sqrt evaluation of uniform samples.
- Replaces the fixed-width, unpipelined detectors: any width, configurable register placement, valid/ready flow control, sideband tag.

Parameters:
- WIDTH, 48: operand width; any value 2..256.
- LVL_PER_STG, 2: binary-tree levels evaluated per register stage, 1..8.
- TAG_W, 4: width of the sideband tag carried alongside each operand.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: operand present.
- in_ready, out, 1: block can accept an operand this cycle.
- in_data, in, WIDTH: operand.
- in_tag, in, TAG_W: sideband, returned unchanged with the result.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_cnt, out, CNT_W = clog2(WIDTH+1): leading-zero count.
- out_zero, out, 1: operand was all zeros.
- out_norm, out, WIDTH: in_data shifted left by out_cnt, zero-filled.
- out_tag, out, TAG_W: tag of the same operand.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: every flop clears immediately on rst_n low, and release is synchronous to clk.
- Reset values: out_valid=0, out_cnt=0, out_zero=0, out_norm=0, out_tag=0, and all internal stage valids=0.
- Padding: the operand is padded on the LSB side with zeros to P = 2^ceil(log2 WIDTH) bits. The padding never affects the result, because the zero case is flagged separately.
- Tree structure:
  - Leaves are 2-bit detectors: {v, p}, with v = OR of the pair and p = 1 when the pair is 01.
  - Each merge node takes left/right (vl,pl)/(vr,pr) and produces v = vl|vr and p = vl ? {0,pl} : {1,pr}.
  - LEVELS = log2 P.
- Register placement: a register follows every LVL_PER_STG tree levels, and the last tree level is always registered. This gives TREE_STG = ceil(LEVELS / LVL_PER_STG).
- Data and tag are delayed alongside the tree.
- Normalise stage: one extra registered stage. It left-shifts the delayed data by the count, forms out_cnt and sets out_zero.
- All-zero operand: out_zero=1, out_cnt=WIDTH, out_norm=0.
- Latency: LAT = TREE_STG + 1 cycles from acceptance to out_valid, when unstalled. With the defaults (P=64, LEVELS=6) LAT = 4.
- Handshake:
  - adv = out_ready | ~out_valid, and in_ready = adv (combinational).
  - When adv=1, all stages shift one position. A stage that receives no operand (in_valid=0 at entry) carries valid=0, i.e. a bubble.
  - When adv=0, every stage holds, including out_* (stable while out_valid & ~out_ready).
- Throughput: one result per cycle while out_ready=1.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Boundary cases:
  - Reset mid-stream discards every in-flight operand; no partial result appears after release.
  - in_valid asserted while in_ready=0: the operand is not taken, and the source must hold it.
  - out_ready=0 with an empty pipeline: in_ready stays 1 until out_valid rises.
- Count arithmetic: unsigned throughout. Counts above WIDTH cannot occur, because padding is on the LSB side.

Decomposition:
- Shared package lzd_pkg holds:
  - function clog2,
  - localparams P, LEVELS, TREE_STG, CNT_W as functions of WIDTH/LVL_PER_STG,
  - the leaf/merge encoding constants.
- Single sub-module lzd_merge: a combinational merge node, parametrised on the child position width. It is instantiated via generate per tree level; leaves use lzd_merge with position width 0.
- Stage registers, valid chain and normaliser stay in lzd_pipe.

Test Plan (WIDTH=48, LVL_PER_STG=2, TAG_W=4, LAT=4):
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0 and all outputs 0. The first accepted operand emerges exactly 4 cycles after acceptance.
- Single operands:
  - in_data=48'h8000_0000_0000, tag=3 → cnt=0, zero=0, norm=48'h8000_0000_0000, tag=3.
  - in_data=48'h0000_0000_0001 → cnt=47, norm=48'h8000_0000_0000.
  - in_data=48'h0000_0F00_0000 → cnt=20, norm=48'hF000_0000_0000.
- Zero: in_data=0, tag=9 → cnt=48, zero=1, norm=0, tag=9.
- Streaming with backpressure:
  - Drive 48 back-to-back operands 1<<(47-k), tag=k[3:0].
  - Hold out_ready=0 for cycles 6–8.
  - Required: results cnt=k in order, outputs stable while stalled, in_ready=0 exactly during the stall, no gaps or duplicates afterwards.
- Reset mid-stream: pulse rst_n low for 1 cycle with 3 operands in flight → out_valid drops asynchronously, and none of the 3 results ever appear. A new operand 48'h1 then yields cnt=47 after 4 cycles.
